// File: rtl/mxint_block_unary_stream.sv
// MXINT block unary unit (PASS/NEG/ABS/NABS) with optional MIN saturation, LANES elements per beat.
// Latency: accept at edge T -> o_valid after edge T+NBEATS; one block per NBEATS+1 cycles.
// Backpressure: result held in DONE until i_ready; a new block is accepted only in IDLE or on the DONE handshake.
module mxint_block_unary_stream #(
  parameter int ELEM_WIDTH  = 8,
  parameter int BLOCK_SIZE  = 32,
  parameter int LANES       = 8,
  parameter int SCALE_WIDTH = 8,
  localparam int NBEATS = BLOCK_SIZE / LANES,
  localparam int CW     = $clog2(BLOCK_SIZE + 1),
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [1:0]                       i_mode,
  input  logic                             i_sat_en,
  input  logic [SCALE_WIDTH-1:0]           i_scale,
  input  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] i_elements,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [SCALE_WIDTH-1:0]           o_scale,
  output logic [BLOCK_SIZE*ELEM_WIDTH-1:0] o_elements,
  output logic [CW-1:0]                    o_ovf_count
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] M_PASS = 2'd0;
  localparam logic [1:0] M_NEG  = 2'd1;
  localparam logic [1:0] M_ABS  = 2'd2;
  localparam logic [1:0] M_NABS = 2'd3;

  localparam logic signed [ELEM_WIDTH-1:0] MIN_V = {1'b1, {(ELEM_WIDTH-1){1'b0}}};
  localparam logic signed [ELEM_WIDTH-1:0] MAX_V = {1'b0, {(ELEM_WIDTH-1){1'b1}}};

  state_t                           state;
  logic [BW-1:0]                    beat;
  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] in_elems;
  logic [SCALE_WIDTH-1:0]           in_scale;
  logic [1:0]                       in_mode;
  logic                             in_sat;
  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] work;
  logic [CW-1:0]                    ovf_acc;
  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] next_work;
  logic [CW-1:0]                    hits;
  logic                             last_beat;

  assign o_ready   = (state == IDLE) | ((state == DONE) & i_ready);
  assign last_beat = (beat == BW'(NBEATS - 1));

  // Per-beat lane datapath: transform the current slice of the captured block and count MIN hits
  always_comb begin
    next_work = work;
    hits      = '0;
    for (int l = 0; l < LANES; l++) begin
      logic signed [ELEM_WIDTH-1:0] x;
      logic signed [ELEM_WIDTH-1:0] r;
      logic                         hit;
      x   = in_elems[(int'(beat) * LANES + l) * ELEM_WIDTH +: ELEM_WIDTH];
      r   = x;
      hit = 1'b0;
      case (in_mode)
        M_NEG: begin
          if (x == MIN_V) begin
            hit = 1'b1;
            r   = in_sat ? MAX_V : MIN_V;
          end else begin
            r = -x;
          end
        end
        M_ABS: begin
          if (x == MIN_V) begin
            hit = 1'b1;
            r   = in_sat ? MAX_V : MIN_V;
          end else if (x < 0) begin
            r = -x;
          end
        end
        M_NABS: begin
          // -x of a positive value is always representable, so no MIN rule here
          if (x > 0) r = -x;
        end
        default: r = x;
      endcase
      next_work[(int'(beat) * LANES + l) * ELEM_WIDTH +: ELEM_WIDTH] = r;
      hits = hits + CW'(hit);
    end
  end

  // Control FSM and registers; outputs publish only when the last beat completes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      beat        <= '0;
      in_elems    <= '0;
      in_scale    <= '0;
      in_mode     <= M_PASS;
      in_sat      <= 1'b0;
      work        <= '0;
      ovf_acc     <= '0;
      o_valid     <= 1'b0;
      o_scale     <= '0;
      o_elements  <= '0;
      o_ovf_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            in_elems <= i_elements;
            in_scale <= i_scale;
            in_mode  <= i_mode;
            in_sat   <= i_sat_en;
            ovf_acc  <= '0;
            beat     <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          work    <= next_work;
          ovf_acc <= ovf_acc + hits;
          if (last_beat) begin
            beat        <= '0;
            state       <= DONE;
            o_valid     <= 1'b1;
            o_elements  <= next_work;
            o_scale     <= in_scale;
            o_ovf_count <= ovf_acc + hits;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            if (i_valid) begin
              in_elems <= i_elements;
              in_scale <= i_scale;
              in_mode  <= i_mode;
              in_sat   <= i_sat_en;
              ovf_acc  <= '0;
              beat     <= '0;
              state    <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mxint_block_unary_stream.sv
// Testbench for mxint_block_unary_stream: default build plus a LANES=32 build.
// Expected blocks are queued at accept and compared when o_valid rises.
// Also covers output hold under i_ready=0, zero-bubble re-accept and mid-block reset.
module tb_mxint_block_unary_stream;

  localparam int NB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid, o_ready, i_sat_en, o_valid, i_ready;
  logic [1:0]   i_mode;
  logic [7:0]   i_scale, o_scale;
  logic [255:0] i_elements, o_elements;
  logic [5:0]   o_ovf_count;

  logic         v2, rdy2, ov2, ir2;
  logic [7:0]   osc2;
  logic [255:0] el2, oel2;
  logic [5:0]   ovf2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [255:0] el;
    logic [7:0]   sc;
    int           ovf;
    int           acc;
  } exp_t;

  exp_t sb[$];
  logic prev_v = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mxint_block_unary_stream dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mode(i_mode), .i_sat_en(i_sat_en), .i_scale(i_scale), .i_elements(i_elements),
    .o_valid(o_valid), .i_ready(i_ready), .o_scale(o_scale),
    .o_elements(o_elements), .o_ovf_count(o_ovf_count)
  );

  mxint_block_unary_stream #(.LANES(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(rdy2),
    .i_mode(2'd1), .i_sat_en(1'b0), .i_scale(8'h11), .i_elements(el2),
    .o_valid(ov2), .i_ready(ir2), .o_scale(osc2),
    .o_elements(oel2), .o_ovf_count(ovf2)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: compute in plain integers, then apply the MIN rule on out-of-range results
  function automatic void model(input logic [1:0] m, input logic s, input logic [255:0] el,
                                output logic [255:0] r, output int ovf);
    r   = '0;
    ovf = 0;
    for (int k = 0; k < 32; k++) begin
      int v;
      int y;
      v = $signed(el[k*8 +: 8]);
      case (m)
        2'd0:    y = v;
        2'd1:    y = -v;
        2'd2:    y = (v < 0) ? -v : v;
        default: y = (v > 0) ? -v : v;
      endcase
      if (y > 127) begin
        ovf++;
        y = s ? 127 : -128;
      end
      r[k*8 +: 8] = y[7:0];
    end
  endfunction

  task automatic send(input logic [1:0] m, input logic s, input logic [7:0] sc,
                      input logic [255:0] el, output int waits);
    exp_t         e;
    logic [255:0] r;
    int           ov;
    waits = 0;
    @(negedge clk);
    i_valid = 1'b1; i_mode = m; i_sat_en = s; i_scale = sc; i_elements = el; i_ready = 1'b1;
    #1;
    while (!o_ready && waits < 100) begin
      @(negedge clk);
      #1;
      waits++;
    end
    chk("accept_ready", o_ready, 1'b1);
    if (o_ready) begin
      @(posedge clk);
      #1;
      model(m, s, el, r, ov);
      e.el = r; e.sc = sc; e.ovf = ov; e.acc = cyc;
      sb.push_back(e);
    end
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || o_valid) && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("drain", sb.size(), 0);
  endtask

  // Scoreboard monitor: compare each result block when o_valid rises
  always @(negedge clk) begin
    if (o_valid && !prev_v) begin
      chk("sb_has_entry", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("elements", o_elements, e.el);
        chk("scale", o_scale, e.sc);
        chk("ovf", o_ovf_count, e.ovf);
        chk("latency", cyc - e.acc, NB);
      end
    end
    prev_v = o_valid;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] el, hold_el, all80, exp32;
    logic [7:0]   hold_sc;
    logic [5:0]   hold_ov;
    int           w, a, t;
    logic         seen;

    rst = 1'b1; i_valid = 1'b0; i_mode = 2'd0; i_sat_en = 1'b0; i_scale = '0;
    i_elements = '0; i_ready = 1'b1; v2 = 1'b0; ir2 = 1'b1; el2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_elements", o_elements, '0);
    chk("rst_scale", o_scale, '0);
    chk("rst_ovf", o_ovf_count, '0);

    // NEG on ramp -16..15
    for (int k = 0; k < 32; k++) begin
      t = k - 16;
      el[k*8 +: 8] = t[7:0];
    end
    send(2'd1, 1'b0, 8'h7F, el, w);
    drain();

    // NEG with one MIN element, wrap then saturate
    el = {32{8'h01}};
    el[3*8 +: 8] = 8'h80;
    send(2'd1, 1'b0, 8'h05, el, w);
    drain();
    send(2'd1, 1'b1, 8'h06, el, w);
    drain();

    // ABS / NABS / PASS on an all-MIN block
    all80 = {32{8'h80}};
    send(2'd2, 1'b1, 8'h01, all80, w);
    drain();
    send(2'd3, 1'b1, 8'h02, all80, w);
    drain();
    send(2'd0, 1'b1, 8'h03, all80, w);
    drain();

    // Mixed random blocks, some MIN codes forced in
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) el[k*32 +: 32] = $urandom;
      el[(i*5)*8 +: 8] = 8'h80;
      send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom), el, w);
      drain();
    end

    // Hold in DONE for 3 cycles, then handshake and accept in the same cycle
    @(negedge clk);
    i_ready = 1'b0;
    for (int k = 0; k < 32; k++) el[k*8 +: 8] = 8'(k * 7);
    send(2'd3, 1'b0, 8'h44, el, w);
    i_ready = 1'b0;
    w = 0;
    while (!o_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("hold_valid", o_valid, 1'b1);
    hold_el = o_elements; hold_sc = o_scale; hold_ov = o_ovf_count;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_valid_stable", o_valid, 1'b1);
      chk("hold_ready_low", o_ready, 1'b0);
      chk("hold_elements", o_elements, hold_el);
      chk("hold_scale", o_scale, hold_sc);
      chk("hold_ovf", o_ovf_count, hold_ov);
    end
    send(2'd2, 1'b0, 8'h55, all80, w);
    chk("b2b_no_wait", w, 0);
    drain();

    // Reset while beat 2 of BUSY is being processed
    send(2'd1, 1'b1, 8'h66, all80, w);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", o_valid, 1'b0);
    chk("midrst_ready", o_ready, 1'b1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    chk("midrst_no_valid", seen, 1'b0);
    el = {32{8'h02}};
    el[0 +: 8] = 8'h80;
    el[31*8 +: 8] = 8'h80;
    send(2'd2, 1'b1, 8'h77, el, w);
    drain();

    // LANES=32 build: single BUSY cycle
    @(negedge clk);
    v2 = 1'b1;
    el2 = {32{8'h01}};
    #1;
    chk("l32_ready", rdy2, 1'b1);
    @(posedge clk);
    #1;
    a = cyc;
    v2 = 1'b0;
    w = 0;
    while (!ov2 && w < 20) begin
      @(negedge clk);
      w++;
    end
    exp32 = {32{8'hFF}};
    chk("l32_valid", ov2, 1'b1);
    chk("l32_latency", cyc - a, 1);
    chk("l32_elements", oel2, exp32);
    chk("l32_ovf", ovf2, '0);
    chk("l32_scale", osc2, 8'h11);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
